mem_access_stage: RTL and testbench

Pipeline MEM stage, directly downstream of execute: EX/MEM register, load/store unit and MEM/WB register.
Drives the data-memory valid/ready port: byte enables and lane replication for stores, byte-lane extraction and sign/zero extension for loads.
Stalls upstream while a memory access waits, with a bounded wait timeout.

---
 rtl/mem_access_stage_if.sv | 23 ++
 rtl/mem_access_stage.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// Data-memory valid/ready port between the MEM stage (master) and data memory (slave).
// Request fields hold steady from assertion until dmem_ready or abandonment.
interface mem_access_stage_if #(
  parameter int ADDRESS_WIDTH = 32
) ();
  logic                     dmem_req;
  logic                     dmem_we;
  logic [ADDRESS_WIDTH-1:0] dmem_addr;
  logic [3:0]               dmem_be;
  logic [31:0]              dmem_wdata;
  logic                     dmem_ready;
  logic [31:0]              dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: EX/MEM reg, load/store lane handling, MEM/WB reg; 1 cycle when dmem_ready arrives with the request.
// Backpressure: stall_m freezes upstream while a request waits, released after at most TIMEOUT request cycles.
module mem_access_stage #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int TIMEOUT       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     reg_write_e,
  input  logic [1:0]               res_src_e,
  input  logic                     mem_write_e,
  input  logic                     mem_read_e,
  input  logic [2:0]               funct3_e,
  input  logic [ADDRESS_WIDTH-1:0] alu_result_e,
  input  logic [31:0]              write_data_e,
  input  logic [4:0]               rd_e,
  input  logic [ADDRESS_WIDTH-1:0] pc_plus4_e,
  mem_access_stage_if.master       dmem,
  output logic                     stall_m,
  output logic                     reg_write_w,
  output logic [1:0]               res_src_w,
  output logic [4:0]               rd_w,
  output logic [ADDRESS_WIDTH-1:0] alu_result_w,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_w,
  output logic [31:0]              read_data_w,
  output logic [1:0]               fault_w
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

  typedef struct packed {
    logic                     reg_write;
    logic [1:0]               res_src;
    logic                     mem_write;
    logic                     mem_read;
    logic [2:0]               funct3;
    logic [ADDRESS_WIDTH-1:0] alu;
    logic [31:0]              wdata;
    logic [4:0]               rd;
    logic [ADDRESS_WIDTH-1:0] pc4;
  } exmem_t;

  typedef struct packed {
    logic                     reg_write;
    logic [1:0]               res_src;
    logic [4:0]               rd;
    logic [ADDRESS_WIDTH-1:0] alu;
    logic [ADDRESS_WIDTH-1:0] pc4;
    logic [31:0]              read_data;
    logic [1:0]               fault;
  } memwb_t;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;
  typedef enum logic {S_IDLE, S_WAIT} state_e;

  exmem_t         ex_d, ex_q;
  memwb_t         wb_d, wb_q;
  state_e         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;

  size_e          size;
  logic [1:0]     lane;
  logic           mem_op;
  logic           misaligned;
  logic           req;
  logic           last_cycle;
  logic           abandon;
  logic           load_signed;
  logic [31:0]    shifted;
  logic [31:0]    load_val;

  // EX/MEM register
  always_comb begin
    ex_d           = '0;
    ex_d.reg_write = reg_write_e;
    ex_d.res_src   = res_src_e;
    ex_d.mem_write = mem_write_e;
    ex_d.mem_read  = mem_read_e;
    ex_d.funct3    = funct3_e;
    ex_d.alu       = alu_result_e;
    ex_d.wdata     = write_data_e;
    ex_d.rd        = rd_e;
    ex_d.pc4       = pc_plus4_e;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
    end else if (!stall_m) begin
      ex_q <= ex_d;
    end
  end

  // Access decode: size, alignment and request qualification
  always_comb begin
    lane        = ex_q.alu[1:0];
    mem_op      = ex_q.mem_read | ex_q.mem_write;
    load_signed = !ex_q.funct3[2];
    case (ex_q.funct3)
      3'b000, 3'b100: size = SZ_B;
      3'b001, 3'b101: size = SZ_H;
      default:        size = SZ_W;
    endcase
    misaligned = mem_op && (((size == SZ_H) && lane[0]) ||
                            ((size == SZ_W) && (lane != 2'b00)));
    req        = mem_op && !misaligned;
  end

  // Request fields are zero whenever no request is presented
  always_comb begin
    dmem.dmem_req   = req;
    dmem.dmem_we    = 1'b0;
    dmem.dmem_addr  = '0;
    dmem.dmem_be    = 4'b0000;
    dmem.dmem_wdata = 32'd0;
    if (req) begin
      dmem.dmem_we   = ex_q.mem_write;
      dmem.dmem_addr = {ex_q.alu[ADDRESS_WIDTH-1:2], 2'b00};
      case (size)
        SZ_B: begin
          dmem.dmem_be    = 4'b0001 << lane;
          dmem.dmem_wdata = {4{ex_q.wdata[7:0]}};
        end
        SZ_H: begin
          dmem.dmem_be    = 4'b0011 << {lane[1], 1'b0};
          dmem.dmem_wdata = {2{ex_q.wdata[15:0]}};
        end
        default: begin
          dmem.dmem_be    = 4'b1111;
          dmem.dmem_wdata = ex_q.wdata;
        end
      endcase
    end
  end

  // Wait FSM: counter tracks request cycles of the current access
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    last_cycle = (cnt == LAST_CNT);
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (req && !dmem.dmem_ready) begin
          state_nxt = S_WAIT;
          cnt_nxt   = cnt + CW'(1);
        end
      end
      S_WAIT: begin
        if (!req || dmem.dmem_ready || last_cycle) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
    stall_m = req && !dmem.dmem_ready && !last_cycle;
    abandon = req && !dmem.dmem_ready && last_cycle;
  end

  // Load lane extraction and extension
  always_comb begin
    shifted = dmem.dmem_rdata >> {lane, 3'b000};
    case (size)
      SZ_B:    load_val = {{24{load_signed & shifted[7]}}, shifted[7:0]};
      SZ_H:    load_val = {{16{load_signed & shifted[15]}}, shifted[15:0]};
      default: load_val = dmem.dmem_rdata;
    endcase
  end

  // MEM/WB next value: bubbles carry only the fault code
  always_comb begin
    wb_d = '0;
    if (stall_m) begin
      wb_d = '0;
    end else if (misaligned) begin
      wb_d.fault = 2'b01;
    end else if (abandon) begin
      wb_d.fault = 2'b10;
    end else begin
      wb_d.reg_write = ex_q.reg_write && !ex_q.mem_write;
      wb_d.res_src   = ex_q.res_src;
      wb_d.rd        = ex_q.rd;
      wb_d.alu       = ex_q.alu;
      wb_d.pc4       = ex_q.pc4;
      wb_d.read_data = ex_q.mem_read ? load_val : 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q <= '0;
    end else begin
      wb_q <= wb_d;
    end
  end

  assign reg_write_w  = wb_q.reg_write;
  assign res_src_w    = wb_q.res_src;
  assign rd_w         = wb_q.rd;
  assign alu_result_w = wb_q.alu;
  assign pc_plus4_w   = wb_q.pc4;
  assign read_data_w  = wb_q.read_data;
  assign fault_w      = wb_q.fault;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage against a per-instruction transaction model.
module tb_mem_access_stage;
  localparam int AW = 32;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          reg_write_e, mem_write_e, mem_read_e;
  logic [1:0]    res_src_e;
  logic [2:0]    funct3_e;
  logic [AW-1:0] alu_result_e, pc_plus4_e;
  logic [31:0]   write_data_e;
  logic [4:0]    rd_e;
  logic          stall_m, reg_write_w;
  logic [1:0]    res_src_w, fault_w;
  logic [4:0]    rd_w;
  logic [AW-1:0] alu_result_w, pc_plus4_w;
  logic [31:0]   read_data_w;

  mem_access_stage_if #(.ADDRESS_WIDTH(AW)) dif ();

  mem_access_stage #(.ADDRESS_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .reg_write_e(reg_write_e), .res_src_e(res_src_e), .mem_write_e(mem_write_e),
    .mem_read_e(mem_read_e), .funct3_e(funct3_e), .alu_result_e(alu_result_e),
    .write_data_e(write_data_e), .rd_e(rd_e), .pc_plus4_e(pc_plus4_e),
    .dmem(dif.master), .stall_m(stall_m),
    .reg_write_w(reg_write_w), .res_src_w(res_src_w), .rd_w(rd_w),
    .alu_result_w(alu_result_w), .pc_plus4_w(pc_plus4_w),
    .read_data_w(read_data_w), .fault_w(fault_w)
  );

  typedef struct {
    logic        rw;
    logic [1:0]  rs;
    logic        mw, mr;
    logic [2:0]  f3;
    logic [31:0] alu, wd;
    logic [4:0]  rd;
    logic [31:0] pc4;
  } instr_t;

  typedef struct {
    bit          full;
    bit          chk_rdata;
    logic        rw;
    logic [1:0]  rs;
    logic [4:0]  rd;
    logic [31:0] alu, pc4, rdata;
    logic [1:0]  fault;
  } wexp_t;

  int    n_vec = 0;
  int    n_err = 0;
  wexp_t exp_w;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic wexp_t zero_w();
    wexp_t w;
    w = '{full: 1'b1, chk_rdata: 1'b1, rw: 1'b0, rs: 2'd0, rd: 5'd0,
          alu: 32'd0, pc4: 32'd0, rdata: 32'd0, fault: 2'd0};
    return w;
  endfunction

  function automatic wexp_t bubble_w(input logic [1:0] f);
    wexp_t w;
    w = zero_w();
    w.full  = 1'b0;
    w.fault = f;
    return w;
  endfunction

  task automatic check_w(input string t);
    check({t, "_rw"},    64'(reg_write_w), 64'(exp_w.rw));
    check({t, "_fault"}, 64'(fault_w),     64'(exp_w.fault));
    if (exp_w.full) begin
      check({t, "_res_src"}, 64'(res_src_w),    64'(exp_w.rs));
      check({t, "_rd"},      64'(rd_w),         64'(exp_w.rd));
      check({t, "_alu"},     64'(alu_result_w), 64'(exp_w.alu));
      check({t, "_pc4"},     64'(pc_plus4_w),   64'(exp_w.pc4));
      if (exp_w.chk_rdata) check({t, "_rdata"}, 64'(read_data_w), 64'(exp_w.rdata));
    end
  endtask

  task automatic drive(input instr_t in);
    reg_write_e  = in.rw;
    res_src_e    = in.rs;
    mem_write_e  = in.mw;
    mem_read_e   = in.mr;
    funct3_e     = in.f3;
    alu_result_e = in.alu;
    write_data_e = in.wd;
    rd_e         = in.rd;
    pc_plus4_e   = in.pc4;
  endtask

  function automatic instr_t rand_instr();
    instr_t r;
    int kind;
    kind  = $urandom_range(0, 2);
    r.rw  = 1'($urandom);
    r.rs  = 2'($urandom);
    r.mr  = (kind == 1);
    r.mw  = (kind == 2);
    r.f3  = 3'($urandom);
    r.alu = $urandom;
    if ($urandom_range(0, 1) == 1) r.alu[1:0] = 2'b00;
    r.wd  = $urandom;
    r.rd  = 5'($urandom);
    r.pc4 = $urandom;
    return r;
  endfunction

  function automatic instr_t mk(input logic rw, input logic mr, input logic mw,
                                input logic [2:0] f3, input logic [31:0] alu,
                                input logic [31:0] wd, input logic [4:0] rd);
    instr_t r;
    r = '{rw: rw, rs: 2'd1, mw: mw, mr: mr, f3: f3, alu: alu, wd: wd, rd: rd,
          pc4: alu + 32'h1000};
    return r;
  endfunction

  // Reference rules: access size in bytes and load result
  function automatic int size_of(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] w, input int off,
                                           input int n, input bit sgn);
    logic [63:0] v, m;
    v = {32'd0, w} >> (8 * off);
    m = (64'd1 << (8 * n)) - 64'd1;
    v = v & m;
    if (sgn && n < 4 && v[8*n-1]) v = v | ~m;
    return v[31:0];
  endfunction

  // Presents one instruction; wait_n = request cycles before dmem_ready (>= TO means never).
  task automatic do_instr(input instr_t in, input int wait_n, input logic [31:0] rdata);
    bit          memop, mis, exp_req, exp_stall, rdy, done;
    int          n, off, k;
    logic [31:0] wexp;
    logic [3:0]  bexp;
    drive(in);
    @(posedge clk);
    @(negedge clk);
    check_w("wb");
    n     = size_of(in.f3);
    off   = int'(in.alu % 32'd4);
    memop = in.mr || in.mw;
    mis   = memop && ((off % n) != 0);
    bexp  = 4'(((1 << n) - 1) << off);
    for (int j = 0; j < 4; j++) wexp[8*j +: 8] = in.wd[8*(j % n) +: 8];
    k    = 0;
    done = 1'b0;
    rdy  = 1'b0;
    exp_req = memop && !mis;
    while (!done) begin
      rdy = exp_req ? (k == wait_n) : 1'($urandom);
      dif.dmem_ready = rdy;
      dif.dmem_rdata = (exp_req && rdy) ? rdata : $urandom;
      #1;
      exp_stall = exp_req && !rdy && (k != TO - 1);
      check("req",   64'(dif.dmem_req), 64'(exp_req));
      check("stall", 64'(stall_m),      64'(exp_stall));
      if (exp_req) begin
        check("addr",  64'(dif.dmem_addr),  64'(in.alu - (in.alu % 32'd4)));
        check("we",    64'(dif.dmem_we),    64'(in.mw));
        check("be",    64'(dif.dmem_be),    64'(bexp));
        if (in.mw) check("wdata", 64'(dif.dmem_wdata), 64'(wexp));
      end
      if (!exp_stall) begin
        done = 1'b1;
      end else begin
        drive(rand_instr());
        @(posedge clk);
        @(negedge clk);
        k++;
        check("bub_rw",    64'(reg_write_w), 64'd0);
        check("bub_fault", 64'(fault_w),     64'd0);
      end
    end
    if (mis) begin
      exp_w = bubble_w(2'b01);
    end else if (exp_req && !rdy) begin
      exp_w = bubble_w(2'b10);
    end else begin
      exp_w           = zero_w();
      exp_w.rw        = in.rw && !in.mw;
      exp_w.rs        = in.rs;
      exp_w.rd        = in.rd;
      exp_w.alu       = in.alu;
      exp_w.pc4       = in.pc4;
      exp_w.chk_rdata = !in.mw;
      exp_w.rdata     = in.mr ? load_val(rdata, off, n, (in.f3 == 3'b000 || in.f3 == 3'b001))
                              : 32'd0;
    end
  endtask

  task automatic check_all_zero(input string t);
    check({t, "_req"},   64'(dif.dmem_req),   64'd0);
    check({t, "_we"},    64'(dif.dmem_we),    64'd0);
    check({t, "_addr"},  64'(dif.dmem_addr),  64'd0);
    check({t, "_be"},    64'(dif.dmem_be),    64'd0);
    check({t, "_wdata"}, 64'(dif.dmem_wdata), 64'd0);
    check({t, "_stall"}, 64'(stall_m),        64'd0);
    exp_w = zero_w();
    check_w(t);
  endtask

  initial begin
    instr_t nop, ld;
    int     w;
    nop = mk(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
    nop.pc4 = 32'd0;
    nop.rs  = 2'd0;
    rst = 1'b1;
    drive(nop);
    dif.dmem_ready = 1'b0;
    dif.dmem_rdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Directed accesses
    do_instr(mk(1'b1, 1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd3), 0, 32'd0);
    do_instr(mk(1'b1, 1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 5'd5), 3, 32'h80FF1234);
    do_instr(mk(1'b1, 1'b1, 1'b0, 3'b101, 32'h102, 32'd0, 5'd6), 1, 32'hBEEF0000);
    do_instr(mk(1'b0, 1'b0, 1'b1, 3'b001, 32'h102, 32'h1234ABCD, 5'd7), 2, 32'd0);
    do_instr(mk(1'b1, 1'b1, 1'b0, 3'b010, 32'h101, 32'd0, 5'd8), 0, 32'd0);
    do_instr(mk(1'b1, 1'b1, 1'b0, 3'b010, 32'h200, 32'd0, 5'd9), 1000, 32'h12345678);
    do_instr(mk(1'b1, 1'b0, 1'b0, 3'b000, 32'h55, 32'd0, 5'd10), 0, 32'd0);

    for (int i = 0; i < 80; i++) begin
      w = ($urandom_range(0, 9) == 0) ? 1000 : int'($urandom_range(0, 4));
      do_instr(rand_instr(), w, $urandom);
    end

    // Reset during WAIT: access dropped, late ready ignored
    ld = mk(1'b1, 1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 5'd12);
    drive(ld);
    @(posedge clk);
    @(negedge clk);
    check_w("pre_rst");
    dif.dmem_ready = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    check("wait_stall", 64'(stall_m), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("mid_rst");
    rst = 1'b0;
    drive(nop);
    dif.dmem_ready = 1'b1;
    dif.dmem_rdata = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("late_rdy");
    dif.dmem_ready = 1'b0;
    exp_w = zero_w();
    do_instr(mk(1'b1, 1'b0, 1'b0, 3'b000, 32'h77, 32'd0, 5'd13), 0, 32'd0);
    do_instr(nop, 0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
